// File: rtl/blink_pkg.sv
// Shared types and helpers for blinker-driven consumers.
package blink_pkg;

   typedef enum logic [1:0] {
      RAMP_UP   = 2'd0,
      HOLD_HI   = 2'd1,
      RAMP_DOWN = 2'd2,
      HOLD_LO   = 2'd3
   } phase_t;

   function automatic int unsigned DUTY_MAX(input int unsigned pwm_w);
      return (32'd1 << pwm_w) - 32'd1;
   endfunction

endpackage

// File: rtl/blink_edge_detect.sv
// Registered rising-edge detector: one-cycle pulse one clock after each 0->1 of in_i.
module blink_edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic in_i,
   output logic rise_o
);

   logic in_q;
   logic rise_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_q   <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         in_q   <= in_i;
         rise_q <= in_i & ~in_q;
      end
   end

   assign rise_o = rise_q;

endmodule

// File: rtl/blink_breather.sv
// Breathing-LED sequencer stepped by blink rising edges, driving the LED through
// a free-running PWM counter.
module blink_breather
   import blink_pkg::*;
#(
   parameter int unsigned PWM_W      = 8,
   parameter int unsigned STEP       = 16,
   parameter int unsigned HOLD_TICKS = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             blink_i,
   input  logic             enable_i,
   output logic             led_o,
   output logic [PWM_W-1:0] duty_o,
   output logic [1:0]       phase_o,
   output logic             step_tick_o
);

   localparam int unsigned CW        = PWM_W + 1;
   localparam int unsigned DMAX      = DUTY_MAX(PWM_W);
   localparam logic [CW-1:0] DMAX_X  = CW'(DMAX);
   localparam logic [CW-1:0] STEP_X  = CW'(STEP);
   localparam logic [7:0]    HOLD_LAST = 8'(HOLD_TICKS - 1);

   phase_t             phase_q, phase_d;
   logic [PWM_W-1:0]   duty_q, duty_d;
   logic [PWM_W-1:0]   pwm_cnt_q, pwm_cnt_d;
   logic [7:0]         hold_q, hold_d;
   logic               led_q, led_d;
   logic               tick;
   logic [CW-1:0]      up_x;

   blink_edge_detect u_edge (
      .clk    (clk),
      .rst    (rst),
      .in_i   (blink_i),
      .rise_o (tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q   <= RAMP_UP;
         duty_q    <= '0;
         pwm_cnt_q <= '0;
         hold_q    <= '0;
         led_q     <= 1'b0;
      end else begin
         phase_q   <= phase_d;
         duty_q    <= duty_d;
         pwm_cnt_q <= pwm_cnt_d;
         hold_q    <= hold_d;
         led_q     <= led_d;
      end
   end

   // Ramp arithmetic is one bit wider so saturation is decided before truncation.
   always_comb begin
      phase_d   = phase_q;
      duty_d    = duty_q;
      hold_d    = hold_q;
      pwm_cnt_d = PWM_W'(pwm_cnt_q + PWM_W'(1));
      led_d     = enable_i & (pwm_cnt_q < duty_q);
      up_x      = {1'b0, duty_q} + STEP_X;

      if (!enable_i) begin
         phase_d = RAMP_UP;
         duty_d  = '0;
         hold_d  = '0;
      end else if (tick) begin
         case (phase_q)
            RAMP_UP: begin
               if (up_x > DMAX_X) begin
                  duty_d  = PWM_W'(DMAX_X);
                  hold_d  = '0;
                  phase_d = HOLD_HI;
               end else begin
                  duty_d = PWM_W'(up_x);
               end
            end
            HOLD_HI: begin
               if (hold_q == HOLD_LAST) begin
                  hold_d  = '0;
                  phase_d = RAMP_DOWN;
               end else begin
                  hold_d = 8'(hold_q + 8'd1);
               end
            end
            RAMP_DOWN: begin
               if ({1'b0, duty_q} < STEP_X) begin
                  duty_d  = '0;
                  hold_d  = '0;
                  phase_d = HOLD_LO;
               end else begin
                  duty_d = PWM_W'({1'b0, duty_q} - STEP_X);
               end
            end
            HOLD_LO: begin
               if (hold_q == HOLD_LAST) begin
                  hold_d  = '0;
                  phase_d = RAMP_UP;
               end else begin
                  hold_d = 8'(hold_q + 8'd1);
               end
            end
            default: phase_d = RAMP_UP;
         endcase
      end
   end

   assign led_o       = led_q;
   assign duty_o      = duty_q;
   assign phase_o     = phase_q;
   assign step_tick_o = tick;

endmodule

// File: tb/tb_blink_breather.sv
// Scoreboard bench for blink_breather: two instances (STEP=16 and STEP=100) share stimulus.
module tb_blink_breather;

   typedef struct packed {
      logic [7:0] d;
      logic [1:0] p;
   } exp_t;
   typedef exp_t exp_q_t[$];

   localparam int HOLD = 4;

   logic clk = 1'b0;
   logic rst, blink, enable;
   logic led0, led1, st0, st1;
   logic [7:0] duty0, duty1;
   logic [1:0] phase0, phase1;

   int total = 0;
   int bad   = 0;

   exp_t seq0[$], seq1[$], q0[$], q1[$];
   exp_t cur0, cur1;
   int   idx0 = 0, idx1 = 0;

   always #5 clk = ~clk;

   blink_breather #(.PWM_W(8), .STEP(16), .HOLD_TICKS(HOLD)) u0 (
      .clk(clk), .rst(rst), .blink_i(blink), .enable_i(enable),
      .led_o(led0), .duty_o(duty0), .phase_o(phase0), .step_tick_o(st0));

   blink_breather #(.PWM_W(8), .STEP(100), .HOLD_TICKS(HOLD)) u1 (
      .clk(clk), .rst(rst), .blink_i(blink), .enable_i(enable),
      .led_o(led1), .duty_o(duty1), .phase_o(phase1), .step_tick_o(st1));

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // One full breathing period as a list of post-tick (duty, phase) states.
   function automatic exp_q_t build(input int step);
      exp_q_t s;
      int d = 0;
      bit done = 0;
      while (!done) begin
         if (d + step > 255) begin d = 255; s.push_back({8'(d), 2'd1}); done = 1; end
         else begin d = d + step; s.push_back({8'(d), 2'd0}); end
      end
      for (int h = 0; h < HOLD - 1; h++) s.push_back({8'd255, 2'd1});
      s.push_back({8'd255, 2'd2});
      done = 0;
      while (!done) begin
         if (d < step) begin d = 0; s.push_back({8'd0, 2'd3}); done = 1; end
         else begin d = d - step; s.push_back({8'(d), 2'd2}); end
      end
      for (int h = 0; h < HOLD - 1; h++) s.push_back({8'd0, 2'd3});
      s.push_back({8'd0, 2'd0});
      return s;
   endfunction

   function automatic void model_park();
      idx0 = 0; idx1 = 0; cur0 = '0; cur1 = '0;
   endfunction

   function automatic void model_tick(input logic en);
      if (en) begin
         cur0 = seq0[idx0]; idx0 = (idx0 + 1) % seq0.size();
         cur1 = seq1[idx1]; idx1 = (idx1 + 1) % seq1.size();
      end else begin
         model_park();
      end
      q0.push_back(cur0);
      q1.push_back(cur1);
   endfunction

   // Blink edge; enable takes value en in the cycle the tick is acted upon.
   task automatic do_tick(input logic en, input int hi, input int lo);
      @(negedge clk);
      blink = 1'b1;
      model_tick(en);
      @(negedge clk);
      enable = en;
      repeat (hi - 2) @(negedge clk);
      blink = 1'b0;
      repeat (lo) @(negedge clk);
   endtask

   task automatic set_enable(input logic v);
      @(negedge clk);
      enable = v;
      if (!v) model_park();
   endtask

   task automatic pwm_check();
      int c0 = 0, c1 = 0;
      repeat (3) @(negedge clk);
      repeat (256) begin
         @(negedge clk);
         c0 += int'(led0);
         c1 += int'(led1);
      end
      chk("pwm_high0", c0, enable ? int'(cur0.d) : 0);
      chk("pwm_high1", c1, enable ? int'(cur1.d) : 0);
   endtask

   always begin
      exp_t e;
      @(negedge clk);
      if (!rst && st0) begin
         @(posedge clk);
         #1;
         if (q0.size() == 0) chk("unexpected_tick0", 1, 0);
         else begin
            e = q0.pop_front();
            chk("duty0", int'(duty0), int'(e.d));
            chk("phase0", int'(phase0), int'(e.p));
         end
      end
   end

   always begin
      exp_t e;
      @(negedge clk);
      if (!rst && st1) begin
         @(posedge clk);
         #1;
         if (q1.size() == 0) chk("unexpected_tick1", 1, 0);
         else begin
            e = q1.pop_front();
            chk("duty1", int'(duty1), int'(e.d));
            chk("phase1", int'(phase1), int'(e.p));
         end
      end
   end

   task automatic chk_reset(input string tag);
      chk({tag, "_led0"}, int'(led0), 0);
      chk({tag, "_duty0"}, int'(duty0), 0);
      chk({tag, "_phase0"}, int'(phase0), 0);
      chk({tag, "_tick0"}, int'(st0), 0);
      chk({tag, "_duty1"}, int'(duty1), 0);
      chk({tag, "_phase1"}, int'(phase1), 0);
   endtask

   initial begin
      rst = 1'b1; blink = 1'b0; enable = 1'b0;
      seq0 = build(16);
      seq1 = build(100);
      model_park();
      #2;
      chk_reset("rst_init");
      repeat (3) @(negedge clk);
      rst = 1'b0;

      pwm_check();
      set_enable(1'b1);
      pwm_check();

      for (int i = 0; i < 4; i++) do_tick(1'b1, 3, 3);
      pwm_check();
      for (int i = 4; i < 23; i++) do_tick(1'b1, 2 + (i % 3), 2 + (i % 2));
      do_tick(1'b0, 3, 3);
      pwm_check();
      do_tick(1'b0, 2, 4);
      set_enable(1'b1);

      for (int i = 0; i < 120; i++) begin
         if ($urandom_range(0, 19) == 0) begin
            set_enable(1'b0);
            repeat ($urandom_range(0, 2)) do_tick(1'b0, 2, 2);
            set_enable(1'b1);
         end
         if (i == 60) pwm_check();
         do_tick($urandom_range(0, 29) != 0, int'($urandom_range(2, 5)), int'($urandom_range(2, 5)));
         if (!enable) set_enable(1'b1);
      end
      repeat (3) @(negedge clk);

      @(negedge clk);
      blink = 1'b1;
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk_reset("rst_mid");
      blink = 1'b0;
      q0.delete(); q1.delete();
      model_park();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) do_tick(1'b1, 3, 2);
      repeat (4) @(negedge clk);
      chk("q0_drained", q0.size(), 0);
      chk("q1_drained", q1.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
